// File: rtl/wb_spi_arbiter.sv
// Round-robin arbiter that lets three Wishbone requesters share one SPI slave port.
// Each grant carries exactly one downstream transfer, which ends in an ack or a timeout error.
module wb_spi_arbiter #(
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  m_cyc_i,
   input  logic [2:0]  m_stb_i,
   input  logic [2:0]  m_we_i,
   input  logic [95:0] m_adr_i,
   input  logic [95:0] m_dat_i,
   input  logic [11:0] m_sel_i,
   output logic [2:0]  m_ack_o,
   output logic [2:0]  m_err_o,
   output logic [31:0] m_dat_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic [3:0]  s_sel_o,
   input  logic        s_ack_i,
   input  logic [31:0] s_dat_i,
   output logic [2:0]  grant_o,
   output logic        busy_o
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] ACK  = 2'd2;
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [1:0]    state_reg;
   logic [2:0]    grant_reg;
   logic [1:0]    last_reg;
   logic [CW-1:0] cnt_reg;
   logic          abort_reg;
   logic [2:0]    m_ack_reg;
   logic [2:0]    m_err_reg;
   logic [31:0]   m_dat_reg;

   logic [3:0]    req;
   logic [1:0]    first, second, third, win_idx;
   logic          owner_cyc;
   logic [31:0]   adr_w [3];
   logic [31:0]   dat_w [3];
   logic [3:0]    sel_w [3];

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_split
         assign adr_w[gi] = m_adr_i[32*gi +: 32];
         assign dat_w[gi] = m_dat_i[32*gi +: 32];
         assign sel_w[gi] = m_sel_i[4*gi +: 4];
      end
   endgenerate

   assign req       = {1'b0, m_cyc_i & m_stb_i};
   assign owner_cyc = |(m_cyc_i & grant_reg);

   // Search order starts one past the previous winner.
   always_comb begin
      case (last_reg)
         2'd0:    begin first = 2'd1; second = 2'd2; third = 2'd0; end
         2'd1:    begin first = 2'd2; second = 2'd0; third = 2'd1; end
         default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
      endcase
      if (req[first])       win_idx = first;
      else if (req[second]) win_idx = second;
      else                  win_idx = third;
   end

   always_comb begin
      s_we_o  = 1'b0;
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      for (int k = 0; k < 3; k++) begin
         if (state_reg == BUSY && grant_reg[k]) begin
            s_we_o  = s_we_o | m_we_i[k];
            s_adr_o = s_adr_o | adr_w[k];
            s_dat_o = s_dat_o | dat_w[k];
            s_sel_o = s_sel_o | sel_w[k];
         end
      end
   end

   // Strobe drops in the ack cycle so the slave never sees a second request.
   assign s_cyc_o = (state_reg == BUSY) & ~s_ack_i;
   assign s_stb_o = s_cyc_o;
   assign grant_o = grant_reg;
   assign busy_o  = (state_reg != IDLE);
   assign m_ack_o = m_ack_reg;
   assign m_err_o = m_err_reg;
   assign m_dat_o = m_dat_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         grant_reg <= '0;
         last_reg  <= 2'd2;
         cnt_reg   <= '0;
         abort_reg <= 1'b0;
         m_ack_reg <= '0;
         m_err_reg <= '0;
         m_dat_reg <= '0;
      end else begin
         m_ack_reg <= '0;
         m_err_reg <= '0;
         case (state_reg)
            IDLE: begin
               if (|req) begin
                  grant_reg <= 3'b001 << win_idx;
                  last_reg  <= win_idx;
                  cnt_reg   <= '0;
                  abort_reg <= 1'b0;
                  state_reg <= BUSY;
               end
            end
            BUSY: begin
               if (!owner_cyc)
                  abort_reg <= 1'b1;
               if (s_ack_i) begin
                  // A requester that abandoned its cycle gets no ack.
                  if (!abort_reg && owner_cyc)
                     m_ack_reg <= grant_reg;
                  m_dat_reg <= s_dat_i;
                  state_reg <= ACK;
               end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                  m_err_reg <= grant_reg;
                  state_reg <= ACK;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            ACK: begin
               grant_reg <= '0;
               state_reg <= IDLE;
            end
            default: begin
               grant_reg <= '0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_spi_arbiter.sv
// Bench for wb_spi_arbiter: one instance with the default timeout and one with TIMEOUT=16
// share all inputs; expected responses go through a scoreboard queue.
module tb_wb_spi_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  m_cyc_i, m_stb_i, m_we_i;
   logic [95:0] m_adr_i, m_dat_i;
   logic [11:0] m_sel_i;
   logic        s_ack_i;
   logic [31:0] s_dat_i;

   logic [2:0]  m_ack_o, m_err_o, grant_o;
   logic [31:0] m_dat_o, s_adr_o, s_dat_o;
   logic        s_cyc_o, s_stb_o, s_we_o, busy_o;
   logic [3:0]  s_sel_o;

   logic [2:0]  t_m_ack_o, t_m_err_o, t_grant_o;
   logic [31:0] t_m_dat_o, t_s_adr_o, t_s_dat_o;
   logic        t_s_cyc_o, t_s_stb_o, t_s_we_o, t_busy_o;
   logic [3:0]  t_s_sel_o;

   typedef struct {
      logic [2:0]  ack;
      logic [2:0]  err;
      logic [31:0] dat;
   } exp_t;
   exp_t sb[$];
   exp_t e;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   wb_spi_arbiter dut (
      .clk(clk), .rst(rst),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
      .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
      .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
      .grant_o(grant_o), .busy_o(busy_o)
   );

   wb_spi_arbiter #(.TIMEOUT(16)) dut_to (
      .clk(clk), .rst(rst),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
      .m_ack_o(t_m_ack_o), .m_err_o(t_m_err_o), .m_dat_o(t_m_dat_o),
      .s_cyc_o(t_s_cyc_o), .s_stb_o(t_s_stb_o), .s_we_o(t_s_we_o),
      .s_adr_o(t_s_adr_o), .s_dat_o(t_s_dat_o), .s_sel_o(t_s_sel_o),
      .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
      .grant_o(t_grant_o), .busy_o(t_busy_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
      m_cyc_i[i] = 1'b1;
      m_stb_i[i] = 1'b1;
      m_we_i[i]  = we;
      m_adr_i[32*i +: 32] = adr;
      m_dat_i[32*i +: 32] = dat;
      m_sel_i[4*i +: 4]   = sel;
   endtask

   task automatic clear_req(input int i);
      m_cyc_i[i] = 1'b0;
      m_stb_i[i] = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Waits (bounded) for a strobe on the main instance, then acks after delay cycles.
   task automatic slave_ack(input int delay, input logic [31:0] rdat, output bit ok);
      int n = 0;
      while (s_stb_o !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      ok = (s_stb_o === 1'b1);
      repeat (delay) tick();
      s_ack_i = 1'b1;
      s_dat_i = rdat;
      tick();
      s_ack_i = 1'b0;
      s_dat_i = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
      m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
      s_ack_i = 1'b0; s_dat_i = '0;
      tick(); tick();
      total_cnt++;
      if ({grant_o, busy_o, m_ack_o, m_err_o} !== 10'd0)
         $display("FAIL reset_ctrl: got grant=%b busy=%b ack=%b err=%b, want all 0", grant_o, busy_o, m_ack_o, m_err_o);
      else pass_cnt++;
      total_cnt++;
      if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, m_dat_o} !== '0)
         $display("FAIL reset_bus: got cyc=%b stb=%b adr=%h dat=%h mdat=%h, want 0", s_cyc_o, s_stb_o, s_adr_o, s_dat_o, m_dat_o);
      else pass_cnt++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_write();
      int rises = 0;
      int gbad = 0;
      logic prev = 1'b0;
      set_req(1, 1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF);
      sb.push_back('{ack: 3'b010, err: 3'b000, dat: 32'h0});
      tick();
      total_cnt++;
      if ({s_we_o, s_adr_o, s_dat_o, s_sel_o} !== {1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF})
         $display("FAIL write_mux: got we=%b adr=%h dat=%h sel=%h, want 1/00000010/a5a5a5a5/f", s_we_o, s_adr_o, s_dat_o, s_sel_o);
      else pass_cnt++;
      for (int i = 0; i < 130; i++) begin
         if (s_stb_o && !prev) rises++;
         prev = s_stb_o;
         if (grant_o !== 3'b010) gbad++;
         tick();
      end
      s_ack_i = 1'b1;
      #1;
      total_cnt++;
      if (s_stb_o !== 1'b0)
         $display("FAIL write_stb_in_ack: got stb=%b, want 0", s_stb_o);
      else pass_cnt++;
      tick();
      s_ack_i = 1'b0;
      total_cnt++;
      if (rises != 1 || gbad != 0)
         $display("FAIL write_strobe: got %0d strobes, %0d bad grant cycles, want 1 and 0", rises, gbad);
      else pass_cnt++;
      e = sb.pop_front();
      total_cnt++;
      if ({m_ack_o, m_err_o, m_dat_o} !== {e.ack, e.err, e.dat})
         $display("FAIL write_ack: got ack=%b err=%b dat=%h, want ack=%b err=%b dat=%h", m_ack_o, m_err_o, m_dat_o, e.ack, e.err, e.dat);
      else pass_cnt++;
      clear_req(1);
      tick();
      total_cnt++;
      if (m_ack_o !== 3'b000 || busy_o !== 1'b0)
         $display("FAIL write_ack_pulse: got ack=%b busy=%b, want 000 and 0", m_ack_o, busy_o);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      bit ok;
      pulse_reset();
      for (int i = 0; i < 3; i++)
         set_req(i, 1'b0, 32'h100 * (i + 1), 32'h0, 4'h3);
      for (int g = 0; g < 4; g++) begin
         sb.push_back('{ack: 3'b001 << (g % 3), err: 3'b000, dat: 32'hC0DE_0000 + g});
         slave_ack(2, 32'hC0DE_0000 + g, ok);
         e = sb.pop_front();
         total_cnt++;
         if (!ok || m_ack_o !== e.ack || grant_o !== e.ack || m_err_o !== 3'b000 || m_dat_o !== e.dat)
            $display("FAIL b2b_grant%0d: got strobe=%0d ack=%b grant=%b err=%b dat=%h, want ack=grant=%b dat=%h",
                     g, ok, m_ack_o, grant_o, m_err_o, m_dat_o, e.ack, e.dat);
         else pass_cnt++;
         if (g == 3) m_cyc_i = '0;
         if (g == 3) m_stb_i = '0;
         tick();
         total_cnt++;
         if (busy_o !== 1'b0 || grant_o !== 3'b000)
            $display("FAIL b2b_idle%0d: got busy=%b grant=%b, want 0 and 000", g, busy_o, grant_o);
         else pass_cnt++;
      end
   endtask

   task automatic test_read();
      bit ok;
      set_req(2, 1'b0, 32'h44, 32'h0, 4'hF);
      sb.push_back('{ack: 3'b100, err: 3'b000, dat: 32'h1234_5678});
      slave_ack(3, 32'h1234_5678, ok);
      e = sb.pop_front();
      total_cnt++;
      if (!ok || {m_ack_o, m_err_o, m_dat_o} !== {e.ack, e.err, e.dat})
         $display("FAIL read: got strobe=%0d ack=%b err=%b dat=%h, want ack=%b dat=%h", ok, m_ack_o, m_err_o, m_dat_o, e.ack, e.dat);
      else pass_cnt++;
      clear_req(2);
      tick(); tick();
   endtask

   task automatic test_timeout();
      int n = 0;
      int stb_hi = 0;
      pulse_reset();
      set_req(0, 1'b1, 32'h8, 32'h1, 4'h1);
      sb.push_back('{ack: 3'b000, err: 3'b001, dat: 32'h0});
      tick();
      while (t_m_err_o === 3'b000 && t_m_ack_o === 3'b000 && n < 40) begin
         if (t_s_stb_o) stb_hi++;
         tick();
         n++;
      end
      e = sb.pop_front();
      total_cnt++;
      if (t_m_err_o !== e.err || t_m_ack_o !== e.ack)
         $display("FAIL timeout_err: got err=%b ack=%b, want err=%b ack=%b", t_m_err_o, t_m_ack_o, e.err, e.ack);
      else pass_cnt++;
      total_cnt++;
      if (stb_hi != 16 || t_s_stb_o !== 1'b0)
         $display("FAIL timeout_stb: got %0d strobe cycles, stb now %b, want 16 and 0", stb_hi, t_s_stb_o);
      else pass_cnt++;
      clear_req(0);
      repeat (4) tick();
      s_ack_i = 1'b1;
      s_dat_i = 32'hBAD0_BAD0;
      tick();
      s_ack_i = 1'b0;
      s_dat_i = '0;
      total_cnt++;
      if (t_m_ack_o !== 3'b000 || t_m_err_o !== 3'b000 || t_m_dat_o !== 32'h0 || t_busy_o !== 1'b0)
         $display("FAIL timeout_stray_ack: got ack=%b err=%b dat=%h busy=%b, want 0s", t_m_ack_o, t_m_err_o, t_m_dat_o, t_busy_o);
      else pass_cnt++;
   endtask

   task automatic test_abort_and_reset();
      int gbad = 0;
      pulse_reset();
      set_req(0, 1'b1, 32'h20, 32'h5, 4'hF);
      tick();
      tick();
      clear_req(0);
      set_req(1, 1'b0, 32'h30, 32'h0, 4'hF);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (grant_o !== 3'b001 || s_stb_o !== 1'b1) gbad++;
      end
      total_cnt++;
      if (gbad != 0)
         $display("FAIL abort_hold: got %0d cycles with grant/stb wrong, want 0", gbad);
      else pass_cnt++;
      sb.push_back('{ack: 3'b000, err: 3'b000, dat: 32'hDEAD_BEEF});
      s_ack_i = 1'b1;
      s_dat_i = 32'hDEAD_BEEF;
      tick();
      s_ack_i = 1'b0;
      s_dat_i = '0;
      e = sb.pop_front();
      total_cnt++;
      if ({m_ack_o, m_err_o, m_dat_o} !== {e.ack, e.err, e.dat} || busy_o !== 1'b1)
         $display("FAIL abort_no_ack: got ack=%b err=%b dat=%h busy=%b, want ack=%b err=%b dat=%h busy=1",
                  m_ack_o, m_err_o, m_dat_o, busy_o, e.ack, e.err, e.dat);
      else pass_cnt++;
      tick();
      tick();
      total_cnt++;
      if (grant_o !== 3'b010)
         $display("FAIL abort_next_grant: got grant=%b, want 010", grant_o);
      else pass_cnt++;
      clear_req(1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total_cnt++;
      if ({grant_o, busy_o, s_stb_o, s_cyc_o, m_ack_o, m_err_o, m_dat_o, s_adr_o} !== '0)
         $display("FAIL reset_mid_busy: got grant=%b busy=%b stb=%b ack=%b err=%b dat=%h adr=%h, want 0s",
                  grant_o, busy_o, s_stb_o, m_ack_o, m_err_o, m_dat_o, s_adr_o);
      else pass_cnt++;
      tick();
      s_ack_i = 1'b1;
      tick();
      s_ack_i = 1'b0;
      total_cnt++;
      if (m_ack_o !== 3'b000 || m_err_o !== 3'b000 || busy_o !== 1'b0)
         $display("FAIL reset_late_ack: got ack=%b err=%b busy=%b, want 000/000/0", m_ack_o, m_err_o, busy_o);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_back_to_back();
      test_read();
      test_timeout();
      test_abort_and_reset();
      total_cnt++;
      if (sb.size() != 0)
         $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
